// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : Bundle between the memory stage, the MEM/WB register and the
//               register file write port.
//               master : memory-stage side (drives stall/flush/in_*)
//               slave  : MEM/WB stage (drives write port, wb_valid, instret)
// Ports       : stall, flush, in_valid, in_regWrite, in_wbSel[1:0],
//               in_rd[4:0], in_funct3[2:0], in_aluResult[N-1:0],
//               in_memData[N-1:0], in_pcPlus4[N-1:0]       (master -> slave)
//               writeReg[4:0], writeData[N-1:0], regWriteEnable,
//               wb_valid, instret[63:0]                     (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
  parameter int N = 32
);
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic          in_regWrite;
  logic [1:0]    in_wbSel;
  logic [4:0]    in_rd;
  logic [2:0]    in_funct3;
  logic [N-1:0]  in_aluResult;
  logic [N-1:0]  in_memData;
  logic [N-1:0]  in_pcPlus4;

  logic [4:0]    writeReg;
  logic [N-1:0]  writeData;
  logic          regWriteEnable;
  logic          wb_valid;
  logic [63:0]   instret;

  modport master (
    output stall, flush, in_valid, in_regWrite, in_wbSel, in_rd, in_funct3,
           in_aluResult, in_memData, in_pcPlus4,
    input  writeReg, writeData, regWriteEnable, wb_valid, instret
  );

  modport slave (
    input  stall, flush, in_valid, in_regWrite, in_wbSel, in_rd, in_funct3,
           in_aluResult, in_memData, in_pcPlus4,
    output writeReg, writeData, regWriteEnable, wb_valid, instret
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and writeback unit. Captures the
//               memory-stage results, extracts and extends load data, selects
//               the writeback source for the register file write port and
//               keeps the 64-bit retired-instruction counter.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               bus  - mem_wb_stage_if.slave (stage inputs, write port,
//                      wb_valid, instret)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int N = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_wb_stage_if.slave    bus
);

  localparam logic [1:0] c_WB_ALU  = 2'b00;
  localparam logic [1:0] c_WB_LOAD = 2'b01;
  localparam logic [1:0] c_WB_LINK = 2'b10;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  // Stage registers
  logic          r_valid;
  logic          r_regWrite;
  logic [1:0]    r_wbSel;
  logic [4:0]    r_rd;
  logic [2:0]    r_funct3;
  logic [N-1:0]  r_aluResult;
  logic [N-1:0]  r_memData;
  logic [N-1:0]  r_pcPlus4;
  logic [63:0]   r_instret;

  logic [7:0]    w_loadByte;
  logic [15:0]   w_loadHalf;
  logic [N-1:0]  w_loadData;
  logic [N-1:0]  w_writeData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_wbSel     <= c_WB_ALU;
      r_rd        <= 5'd0;
      r_funct3    <= 3'd0;
      r_aluResult <= '0;
      r_memData   <= '0;
      r_pcPlus4   <= '0;
      r_instret   <= 64'd0;
    end else begin
      // The held entry retires as it leaves the stage; a stalled entry does
      // not leave, so a flush during a stall discards it uncounted.
      if (r_valid && !bus.stall) begin
        r_instret <= r_instret + 64'd1;
      end

      if (bus.flush) begin
        r_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_valid     <= bus.in_valid;
        r_regWrite  <= bus.in_regWrite;
        r_wbSel     <= bus.in_wbSel;
        r_rd        <= bus.in_rd;
        r_funct3    <= bus.in_funct3;
        r_aluResult <= bus.in_aluResult;
        r_memData   <= bus.in_memData;
        r_pcPlus4   <= bus.in_pcPlus4;
      end
    end
  end

  // Load alignment: memory returns the whole aligned word, the low address
  // bits pick the byte/halfword lane.
  always_comb begin
    w_loadByte = r_memData[7:0];
    case (r_aluResult[1:0])
      2'b00:   w_loadByte = r_memData[7:0];
      2'b01:   w_loadByte = r_memData[15:8];
      2'b10:   w_loadByte = r_memData[23:16];
      default: w_loadByte = r_memData[31:24];
    endcase

    w_loadHalf = r_aluResult[1] ? r_memData[31:16] : r_memData[15:0];

    case (r_funct3)
      c_F3_LB:  w_loadData = {{(N-8){w_loadByte[7]}}, w_loadByte};
      c_F3_LBU: w_loadData = {{(N-8){1'b0}}, w_loadByte};
      c_F3_LH:  w_loadData = {{(N-16){w_loadHalf[15]}}, w_loadHalf};
      c_F3_LHU: w_loadData = {{(N-16){1'b0}}, w_loadHalf};
      default:  w_loadData = r_memData;
    endcase
  end

  // Reserved source code 11 falls back to the ALU result.
  always_comb begin
    case (r_wbSel)
      c_WB_LOAD: w_writeData = w_loadData;
      c_WB_LINK: w_writeData = r_pcPlus4;
      default:   w_writeData = r_aluResult;
    endcase
  end

  assign bus.writeReg       = r_rd;
  assign bus.writeData      = w_writeData;
  assign bus.regWriteEnable = r_valid && r_regWrite && (r_rd != 5'd0);
  assign bus.wb_valid       = r_valid;
  assign bus.instret        = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. Expected write-port
//               values are queued when an instruction is driven and compared
//               when it appears at the write port one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  logic clk;
  logic rst;
  int   nTests;
  int   nFail;
  logic [63:0] expCnt;
  exp_t sbq[$];

  mem_wb_stage_if #(.N(32)) bus ();

  mem_wb_stage #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc);
    bus.in_valid     = v;
    bus.in_regWrite  = rw;
    bus.in_wbSel     = sel;
    bus.in_rd        = rd;
    bus.in_funct3    = f3;
    bus.in_aluResult = alu;
    bus.in_memData   = mem;
    bus.in_pcPlus4   = pc;
  endtask

  task automatic idle();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic we);
    exp_t e;
    e.rd = rd; e.data = data; e.we = we;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    nTests++;
    if (bus.wb_valid !== 1'b0 || bus.regWriteEnable !== 1'b0 || bus.instret !== 64'd0) begin
      nFail++;
      $display("FAIL reset_initial: valid=%b we=%b instret=%0d expected 0/0/0",
               bus.wb_valid, bus.regWriteEnable, bus.instret);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 5'd3, 3'b010, 32'h100, 32'h12345678, 32'h0);
    @(negedge clk);
    nTests++;
    if (bus.regWriteEnable !== 1'b1 || bus.writeData !== 32'h12345678) begin
      nFail++;
      $display("FAIL reset_lw_loaded: we=%b data=%h expected 1/12345678",
               bus.regWriteEnable, bus.writeData);
    end
    #2 rst = 1'b0;
    #1;
    nTests++;
    if (bus.regWriteEnable !== 1'b0 || bus.wb_valid !== 1'b0 || bus.instret !== 64'd0) begin
      nFail++;
      $display("FAIL reset_async: we=%b valid=%b instret=%0d expected 0/0/0",
               bus.regWriteEnable, bus.wb_valid, bus.instret);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nTests++;
    if (bus.wb_valid !== 1'b0 || bus.regWriteEnable !== 1'b0 || bus.writeData !== 32'h0 ||
        bus.writeReg !== 5'd0 || bus.instret !== 64'd0) begin
      nFail++;
      $display("FAIL reset_release: valid=%b we=%b data=%h reg=%0d instret=%0d expected all 0",
               bus.wb_valid, bus.regWriteEnable, bus.writeData, bus.writeReg, bus.instret);
    end
    expCnt = 64'd0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011, 3'b101};
    logic [31:0] alus [8] = '{32'h103, 32'h100, 32'h102, 32'h100, 32'h100, 32'h101, 32'h102, 32'h103};
    logic [31:0] exps [8] = '{32'hFFFFFF88, 32'h000000BB, 32'hFFFF8899, 32'h0000AABB,
                              32'h8899AABB, 32'hFFFFFFAA, 32'h8899AABB, 32'h00008899};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b01, 5'(i + 1), f3s[i], alus[i], 32'h8899AABB, 32'h0);
      push(5'(i + 1), exps[i], 1'b1);
      @(negedge clk);
      nTests++;
      if (sbq.size() == 0) begin
        nFail++;
        $display("FAIL load_%0d: scoreboard empty", i);
      end else begin
        e = sbq.pop_front();
        if (bus.writeData !== e.data || bus.writeReg !== e.rd || bus.regWriteEnable !== e.we) begin
          nFail++;
          $display("FAIL load_%0d: data=%h reg=%0d we=%b expected %h/%0d/%b",
                   i, bus.writeData, bus.writeReg, bus.regWriteEnable, e.data, e.rd, e.we);
        end
      end
    end
    idle();
    @(negedge clk);
    expCnt += 64'd8;
    nTests++;
    if (bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL load_instret: got %0d expected %0d", bus.instret, expCnt);
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 1'b1, 2'b10, 5'd1, 3'd0, 32'h0000_0500, 32'h0, 32'h0000_0044);
    @(negedge clk);
    nTests++;
    if (bus.writeData !== 32'h44 || bus.writeReg !== 5'd1 || bus.regWriteEnable !== 1'b1) begin
      nFail++;
      $display("FAIL jal_rd1: data=%h reg=%0d we=%b expected 44/1/1",
               bus.writeData, bus.writeReg, bus.regWriteEnable);
    end
    drive(1'b1, 1'b1, 2'b10, 5'd0, 3'd0, 32'h0000_0500, 32'h0, 32'h0000_0044);
    @(negedge clk);
    nTests++;
    if (bus.regWriteEnable !== 1'b0 || bus.writeReg !== 5'd0 || bus.wb_valid !== 1'b1) begin
      nFail++;
      $display("FAIL jal_rd0: we=%b reg=%0d valid=%b expected 0/0/1",
               bus.regWriteEnable, bus.writeReg, bus.wb_valid);
    end
    idle();
    @(negedge clk);
    expCnt += 64'd2;
    nTests++;
    if (bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL jal_instret: got %0d expected %0d", bus.instret, expCnt);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    drive(1'b1, 1'b1, 2'b00, 5'd5, 3'd0, 32'h1234, 32'h0, 32'h0);
    push(5'd5, 32'h1234, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      drive(1'b1, 1'b1, 2'b00, 5'(7 + i), 3'd0, 32'hDEAD0000 + i, 32'h0, 32'h0);
      nTests++;
      if (sbq.size() == 0) begin
        nFail++;
        $display("FAIL stall_%0d: scoreboard empty", i);
      end else begin
        e = sbq[0];
        if (bus.writeData !== e.data || bus.writeReg !== e.rd || bus.regWriteEnable !== e.we ||
            bus.instret !== expCnt) begin
          nFail++;
          $display("FAIL stall_%0d: data=%h reg=%0d we=%b instret=%0d expected %h/%0d/%b/%0d",
                   i, bus.writeData, bus.writeReg, bus.regWriteEnable, bus.instret,
                   e.data, e.rd, e.we, expCnt);
        end
      end
      @(negedge clk);
    end
    nTests++;
    if (bus.writeData !== 32'h1234 || bus.writeReg !== 5'd5 || bus.regWriteEnable !== 1'b1 ||
        bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL stall_held: data=%h reg=%0d we=%b instret=%0d expected 1234/5/1/%0d",
               bus.writeData, bus.writeReg, bus.regWriteEnable, bus.instret, expCnt);
    end
    if (sbq.size() != 0) e = sbq.pop_front();
    idle();
    @(negedge clk);
    expCnt += 64'd1;
    nTests++;
    if (bus.instret !== expCnt || bus.wb_valid !== 1'b0) begin
      nFail++;
      $display("FAIL stall_release: instret=%0d valid=%b expected %0d/0",
               bus.instret, bus.wb_valid, expCnt);
    end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 5'd8, 3'd0, 32'hABCD, 32'h0, 32'h0);
    @(negedge clk);
    nTests++;
    if (bus.wb_valid !== 1'b0 || bus.regWriteEnable !== 1'b0) begin
      nFail++;
      $display("FAIL flush_capture: valid=%b we=%b expected 0/0", bus.wb_valid, bus.regWriteEnable);
    end
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 5'd9, 3'd0, 32'h9999, 32'h0, 32'h0);
    @(negedge clk);
    nTests++;
    if (bus.regWriteEnable !== 1'b1 || bus.writeReg !== 5'd9) begin
      nFail++;
      $display("FAIL flush_load9: we=%b reg=%0d expected 1/9", bus.regWriteEnable, bus.writeReg);
    end
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    nTests++;
    if (bus.wb_valid !== 1'b0 || bus.regWriteEnable !== 1'b0 || bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL flush_with_stall: valid=%b we=%b instret=%0d expected 0/0/%0d",
               bus.wb_valid, bus.regWriteEnable, bus.instret, expCnt);
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 5'd10, 3'd0, 32'hAAAA, 32'h0, 32'h0);
    @(negedge clk);
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 5'd11, 3'd0, 32'hBBBB, 32'h0, 32'h0);
    @(negedge clk);
    expCnt += 64'd1;
    nTests++;
    if (bus.wb_valid !== 1'b0 || bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL flush_retire: valid=%b instret=%0d expected 0/%0d",
               bus.wb_valid, bus.instret, expCnt);
    end
    idle();
    @(negedge clk);
    nTests++;
    if (bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL flush_bubble_count: instret=%0d expected %0d", bus.instret, expCnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expCnt = 64'd0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'b00, 5'(11 + i), 3'd0, 32'h11 * (i + 1), 32'h0, 32'h0);
      push(5'(11 + i), 32'h11 * (i + 1), 1'b1);
      @(negedge clk);
      nTests++;
      if (sbq.size() == 0) begin
        nFail++;
        $display("FAIL b2b_%0d: scoreboard empty", i);
      end else begin
        e = sbq.pop_front();
        if (bus.writeData !== e.data || bus.writeReg !== e.rd || bus.regWriteEnable !== e.we) begin
          nFail++;
          $display("FAIL b2b_%0d: data=%h reg=%0d we=%b expected %h/%0d/%b",
                   i, bus.writeData, bus.writeReg, bus.regWriteEnable, e.data, e.rd, e.we);
        end
      end
    end
    idle();
    @(negedge clk);
    expCnt += 64'd10;
    nTests++;
    if (bus.instret !== 64'd10 || bus.instret !== expCnt) begin
      nFail++;
      $display("FAIL b2b_instret: got %0d expected 10", bus.instret);
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    expCnt = 64'd0;
    rst    = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_loads();
    test_jal();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback unit of the single-memory pipelined RISC-V core.
- Captures the memory-stage results and aligns and sign/zero-extends load data.
- Selects the writeback source and drives the register file write port (writeReg, writeData, regWriteEnable).
- Keeps the 64-bit retired-instruction counter.

Parameters:
N, 32, datapath width; fixed at 32 for RV32I, present for consistency with the register file.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
stall  input  1  hold stage contents (single-memory structural hazard or downstream stall)
flush  input  1  squash the entry being captured
in_valid  input  1  memory stage holds a real instruction
in_regWrite  input  1  instruction writes rd
in_wbSel  input  2  00 ALU result, 01 load data, 10 PC+4 (link), 11 reserved -> ALU result
in_rd  input  5  destination register
in_funct3  input  3  load size/sign code
in_aluResult  input  N  ALU result / effective address
in_memData  input  N  raw 32-bit word read from memory (word-aligned)
in_pcPlus4  input  N  link value
writeReg  output  5  register file write address
writeData  output  N  register file write data
regWriteEnable  output  1  register file write enable
wb_valid  output  1  stage holds a valid instruction
instret  output  64  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous): all stage registers clear.
  - wb_valid=0, regWriteEnable=0, writeReg=0, writeData=0, instret=0.
  - Takes effect immediately, mid-operation included; no partial write survives.
- Capture at posedge clk, rst=1, priority flush > stall > load:
  - flush=1: valid register <= 0; the other fields may load but are don't-care.
  - stall=1 (flush=0): every stage register holds.
  - otherwise: every field <= its in_* input, valid <= in_valid.
- Latency: one cycle from the in_* inputs to writeReg/writeData/regWriteEnable. Outputs are combinational from the stage registers only, never from in_*.
- regWriteEnable = valid & regWrite & (rd != 0).
  - Stays asserted while the stage is stalled; the repeated write is idempotent.
  - rd=0 never asserts the enable.
- writeReg = registered rd, even when regWriteEnable=0.
- Load extraction, off = aluResult[1:0]:
  - 000 LB: byte off, sign-extended.
  - 100 LBU: byte off, zero-extended.
  - 001 LH: halfword aluResult[1] (bytes 1:0 or 3:2), sign-extended; aluResult[0] ignored.
  - 101 LHU: same selection, zero-extended.
  - 010 LW and all other codes: full word; offset ignored.
- writeData: wbSel 01 -> extracted load data; 10 -> pcPlus4; 00/11 -> aluResult. Computed even when invalid; that value is don't-care.
- wb_valid = valid register.
- instret:
  - +1 on each posedge where valid=1 and stall=0, i.e. the entry retires as it leaves the stage.
  - An instruction that writes nothing still counts if valid.
  - A flushed bubble never counts.
  - Wraps 2^64-1 -> 0 with no flag.
- Simultaneous events:
  - flush with stall: the flush wins; the held valid entry is not counted and is replaced by a bubble.
  - flush while the stage holds a valid entry that is not stalled: that entry retires and counts this edge; the next contents are a bubble.
- No X propagation: every register is reset.

Test Plan:
1. Reset: drive rst=0 mid-stream with a valid LW in the stage -> the same cycle shows regWriteEnable=0, wb_valid=0, instret=0; after release with inputs idle, outputs stay 0.
2. Loads, in_memData=0x8899AABB:
   - LB, aluResult=0x103 -> writeData=0xFFFFFF88.
   - LBU, off 0 -> 0x000000BB.
   - LH, aluResult=0x102 -> 0xFFFF8899.
   - LHU, off 0 -> 0x0000AABB.
   - LW -> 0x8899AABB.
   In each case writeReg=rd and regWriteEnable=1 exactly one cycle after capture.
3. JAL: in_wbSel=10, in_pcPlus4=0x00000044, rd=1 -> writeData=0x44, writeReg=1. The same instruction with rd=0 -> regWriteEnable=0 but instret still increments.
4. Stall: capture ADD (aluResult=0x1234, rd=5), then stall=1 for 3 cycles with new inputs changing -> outputs hold 0x1234/5 and regWriteEnable=1 throughout; instret increments by exactly 1, on the first unstalled edge.
5. Flush: assert flush with a valid input -> next cycle wb_valid=0, regWriteEnable=0. With stall=1 and flush=1 together -> the held entry becomes a bubble and instret is unchanged.
6. Throughput: 10 back-to-back valid instructions, no stall -> instret=10 after the last one leaves, and one register-file write per cycle in order.
